// File: rtl/gates_bist_if.sv
// Signal bundle between the BIST sequencer, its control source and the gates datapath.
// The slave side is the sequencer; the master side is the lab controller plus gates instance.
interface gates_bist_if;
    logic        start;
    logic        abort;
    logic        a;
    logic        b;
    logic        y_and;
    logic        y_or;
    logic        y_xor;
    logic        busy;
    logic        done;
    logic        pass;
    logic [3:0]  fail_mask;
    logic [11:0] result;

    modport master (
        output start, abort, y_and, y_or, y_xor,
        input  a, b, busy, done, pass, fail_mask, result
    );

    modport slave (
        input  start, abort, y_and, y_or, y_xor,
        output a, b, busy, done, pass, fail_mask, result
    );
endinterface

// File: rtl/gates_bist.sv
// Built-in self-test sequencer: walks all four {b,a} vectors through a gates instance,
// waits SETTLE cycles per vector, captures and checks the AND/OR/XOR responses.
module gates_bist #(
    parameter int unsigned SETTLE = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    gates_bist_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

    // Reference response of a fault-free gates block, packed as {and,or,xor}.
    function automatic logic [2:0] expect_fn(input logic b_in, input logic a_in);
        return {b_in & a_in, b_in | a_in, b_in ^ a_in};
    endfunction

    state_t      state_r, state_s;
    logic [1:0]  idx_r, idx_s;
    logic [3:0]  cnt_r, cnt_s;
    logic [1:0]  vec_r, vec_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic        pass_r, pass_s;
    logic [3:0]  fail_mask_r, fail_mask_s;
    logic [11:0] result_r, result_s;
    logic [2:0]  captured_s;
    logic        mismatch_s;

    assign captured_s = {bus.y_and, bus.y_or, bus.y_xor};
    // Expected values come from the registered stimulus, not from the vector index.
    assign mismatch_s = (captured_s != expect_fn(vec_r[1], vec_r[0]));

    // Next-state and next-output decode for the sequencer.
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        cnt_s       = cnt_r;
        vec_s       = vec_r;
        pass_s      = pass_r;
        fail_mask_s = fail_mask_r;
        result_s    = result_r;

        case (state_r)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_s     = ST_WAIT;
                    idx_s       = 2'd0;
                    vec_s       = 2'b00;
                    cnt_s       = SETTLE_M1;
                    result_s    = 12'h000;
                    fail_mask_s = 4'b0000;
                    pass_s      = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (bus.abort) begin
                    state_s = ST_IDLE;
                    vec_s   = 2'b00;
                    pass_s  = 1'b0;
                end else if (cnt_r == 4'd0) begin
                    state_s = ST_SAMPLE;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_SAMPLE: begin
                if (bus.abort) begin
                    state_s = ST_IDLE;
                    vec_s   = 2'b00;
                    pass_s  = 1'b0;
                end else begin
                    result_s[3*idx_r +: 3] = captured_s;
                    fail_mask_s[idx_r]     = mismatch_s;
                    if (idx_r == 2'd3) begin
                        // Resolve pass here so it is already valid during the done pulse.
                        state_s = ST_DONE;
                        pass_s  = (fail_mask_s == 4'b0000);
                    end else begin
                        state_s = ST_WAIT;
                        idx_s   = idx_r + 2'd1;
                        vec_s   = idx_r + 2'd1;
                        cnt_s   = SETTLE_M1;
                    end
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                vec_s   = 2'b00;
                pass_s  = (fail_mask_r == 4'b0000);
            end
            default: begin
                state_s = ST_IDLE;
                vec_s   = 2'b00;
            end
        endcase

        busy_s = (state_s == ST_WAIT) || (state_s == ST_SAMPLE);
        done_s = (state_s == ST_DONE);
    end

    // State and output registers; every output is a flop so nothing glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            idx_r       <= 2'd0;
            cnt_r       <= 4'd0;
            vec_r       <= 2'b00;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            fail_mask_r <= 4'b0000;
            result_r    <= 12'h000;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            cnt_r       <= cnt_s;
            vec_r       <= vec_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            pass_r      <= pass_s;
            fail_mask_r <= fail_mask_s;
            result_r    <= result_s;
        end
    end

    assign bus.a         = vec_r[0];
    assign bus.b         = vec_r[1];
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.pass      = pass_r;
    assign bus.fail_mask = fail_mask_r;
    assign bus.result    = result_r;

endmodule
